// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int unsigned UART_BITS = 8;

  // Clocks per bit, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; expire_o is high while the count sits at zero.
// Loading value L makes expire_o assert L cycles after the load cycle ends.
module uart_bit_timer #(
  parameter int unsigned DIV = 16,
  localparam int unsigned W  = $clog2(DIV)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with single-entry holding register, valid/ack
// handshake, sticky overrun, frame-error pulse and LED mirror.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DIV    = uart_div(CLK_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [UART_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy,
  output logic [UART_BITS-1:0] led
);

  localparam int unsigned    CW     = $clog2(DIV);
  localparam logic [CW-1:0]  HALF   = CW'(DIV / 2);
  // Reload with DIV-1 so the next expiry lands exactly DIV cycles later.
  localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

  logic sync1_q, sync2_q, prev_q;
  logic fall;

  uart_rx_state_t       state_q;
  logic [2:0]           bitidx_q;
  logic [UART_BITS-1:0] shreg_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          expire;

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Timer load requests: half-bit on start edge, full bit on each accepted sample.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = RELOAD;
    case (state_q)
      IDLE: begin
        if (fall) begin
          tmr_load = 1'b1;
          tmr_val  = HALF;
        end
      end
      START:   tmr_load = expire & ~sync2_q;
      DATA:    tmr_load = expire;
      default: tmr_load = 1'b0;
    endcase
  end

  uart_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (expire)
  );

  // Receive FSM, shift register, holding register and handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bitidx_q  <= '0;
      shreg_q   <= '0;
      data      <= '0;
      led       <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (expire) begin
            if (sync2_q) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              bitidx_q <= '0;
              state_q  <= DATA;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shreg_q <= {sync2_q, shreg_q[UART_BITS-1:1]};
            if (bitidx_q == 3'(UART_BITS - 1)) begin
              state_q <= STOP;
            end else begin
              bitidx_q <= bitidx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (expire) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            if (sync2_q) begin
              // A load overrides the ack clear above: new byte wins.
              data  <= shreg_q;
              led   <= shreg_q;
              valid <= 1'b1;
              if (valid && !ack) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: directed test-plan items plus
// randomized frames, checked against an event-level reference model.
module tb_uart_rx_monitor;

  localparam int unsigned DIV      = 16;
  localparam int unsigned FRAME_HI = 9 * DIV + DIV / 2 + 1;
  localparam int unsigned FALSE_HI = DIV / 2 + 1;

  typedef enum int {K_GOOD, K_FERR, K_FALSE} kind_t;
  typedef struct {
    kind_t      k;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic       ack_man = 1'b0;
  logic       rand_en = 1'b0;
  logic [7:0] data, led;
  logic       valid, overrun, frame_err, busy;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  uart_rx_monitor #(
    .CLK_HZ(160),
    .BAUD  (10)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy),
    .led      (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ack source: random in the soak phase, manual otherwise.
  always @(posedge clk) begin
    #2;
    ack = rand_en ? ($urandom_range(0, 5) == 0) : ack_man;
  end

  // Reference model: holding-register state evolved per cycle from ack and
  // the end-of-frame events predicted by the stimulus queue.
  logic       m_valid, m_ovr;
  logic [7:0] m_data, m_led;
  logic       busy_prev, ack_prev;
  int         busy_len;

  always @(negedge clk) begin
    logic old_valid, exp_ferr;
    exp_t r;
    if (!reset_n) begin
      m_valid = 0; m_ovr = 0; m_data = '0; m_led = '0;
      busy_prev = 0; ack_prev = 0; busy_len = 0;
    end else begin
      exp_ferr  = 0;
      old_valid = m_valid;
      if (ack_prev && m_valid) begin
        m_valid = 0;
        m_ovr   = 0;
      end
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          r = exp_q.pop_front();
          case (r.k)
            K_GOOD: begin
              chk("busy_len_good", busy_len, FRAME_HI);
              if (old_valid && !ack_prev) m_ovr = 1;
              m_valid = 1;
              m_data  = r.b;
              m_led   = r.b;
            end
            K_FERR: begin
              chk("busy_len_ferr", busy_len, FRAME_HI);
              exp_ferr = 1;
            end
            default: chk("busy_len_false", busy_len, FALSE_HI);
          endcase
        end
      end
      chk("valid", valid, m_valid);
      chk("overrun", overrun, m_ovr);
      chk("frame_err", frame_err, exp_ferr);
      chk("led", led, m_led);
      if (m_valid) chk("data", data, m_data);
      busy_len  = busy ? busy_len + 1 : 0;
      busy_prev = busy;
      ack_prev  = ack;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t r;
    r.k = stop ? K_GOOD : K_FERR;
    r.b = b;
    exp_q.push_back(r);
    rxd = 1'b0;
    wait_cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(DIV);
    end
    rxd = stop;
    wait_cyc(DIV);
    rxd = 1'b1;
  endtask

  task automatic false_start(input int unsigned len);
    exp_t r;
    r.k = K_FALSE;
    r.b = '0;
    exp_q.push_back(r);
    rxd = 1'b0;
    wait_cyc(len);
    rxd = 1'b1;
    wait_cyc(2 * DIV);
  endtask

  task automatic pulse_ack();
    ack_man = 1'b1;
    wait_cyc(1);
    ack_man = 1'b0;
  endtask

  task automatic wait_busy(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (busy) begin
        ok = 1'b1;
        break;
      end
      wait_cyc(1);
    end
  endtask

  initial begin
    logic ok;
    wait_cyc(3);
    chk("rst_data", data, 0);
    chk("rst_led", led, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Single byte
    send_frame(8'hA5, 1'b1);
    chk("single_data", data, 8'hA5);
    chk("single_led", led, 8'hA5);
    chk("single_valid", valid, 1);
    chk("single_busy", busy, 0);
    pulse_ack();
    chk("single_ack_valid", valid, 0);
    wait_cyc(DIV);

    // False start
    false_start(4);
    chk("false_valid", valid, 0);

    // Frame error
    send_frame(8'h3C, 1'b0);
    wait_cyc(2 * DIV);
    chk("ferr_led", led, 8'hA5);
    chk("ferr_valid", valid, 0);

    // Overrun then ack
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_data", data, 8'h22);
    chk("ovr_flag", overrun, 1);
    pulse_ack();
    chk("ovr_ack_valid", valid, 0);
    chk("ovr_ack_flag", overrun, 0);
    wait_cyc(DIV);

    // Simultaneous ack and load
    send_frame(8'h11, 1'b1);
    wait_cyc(DIV);
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_busy(ok);
        chk("sim_busy_rise", ok, 1);
        wait_cyc(DIV / 2 + 9 * DIV);
        ack_man = 1'b1;
        wait_cyc(1);
        ack_man = 1'b0;
        chk("sim_valid", valid, 1);
        chk("sim_data", data, 8'h22);
        chk("sim_overrun", overrun, 0);
      end
    join
    pulse_ack();
    wait_cyc(DIV);

    // Break: one frame error, no restart until a fresh falling edge
    begin
      exp_t r;
      r.k = K_FERR;
      r.b = '0;
      exp_q.push_back(r);
    end
    rxd = 1'b0;
    wait_cyc(14 * DIV);
    rxd = 1'b1;
    wait_cyc(3 * DIV);

    // Reset mid-frame during data bit 3 of 0xFF
    send_frame(8'h77, 1'b1);
    wait_cyc(DIV);
    rxd = 1'b0;
    wait_cyc(DIV);
    rxd = 1'b1;
    wait_cyc(3 * DIV + DIV / 2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_data", data, 0);
    chk("arst_led", led, 0);
    chk("arst_valid", valid, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_ferr", frame_err, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(4);
    send_frame(8'h5A, 1'b1);
    chk("post_rst_data", data, 8'h5A);
    chk("post_rst_led", led, 8'h5A);
    pulse_ack();
    wait_cyc(DIV);

    // Randomized soak with random ack
    rand_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        false_start($urandom_range(1, 6));
      end else begin
        send_frame(8'($urandom), (sel != 1));
        if ($urandom_range(0, 1) == 1) wait_cyc($urandom_range(1, 2 * DIV));
      end
    end
    wait_cyc(2 * DIV);
    rand_en = 1'b0;
    wait_cyc(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Board-level UART receiver that listens to the SoC's serial transmit line (`uart_tx`, 8N1) and recovers bytes for on-board consumers: LED display and debug capture. It is the receiving end of the SoC's UART transmitter. It runs in the 10 MHz SoC clock domain at 9600 baud by default. Each byte is presented through a single-entry holding register with a valid/ack handshake, and the last good byte is mirrored on an LED bus.

## Interface
Parameters:
- `CLK_HZ`, 10_000_000, input clock frequency.
- `BAUD`, 9600, line rate.
- `DIV`, `CLK_HZ/BAUD` (integer truncation, 1041 by default), clocks per bit; must be ≥ 4.

Ports:
- `clk`  in  1  SoC clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line, idle high, asynchronous to `clk`.
- `data`  out  8  received byte; valid while `valid`=1.
- `valid`  out  1  holding register full.
- `ack`  in  1  consumer has taken `data`.
- `overrun`  out  1  sticky: a byte was overwritten before it was acked.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `busy`  out  1  high while the FSM is not in IDLE.
- `led`  out  8  last byte received without error.

## Operation
- Input synchroniser: 2-FF on `rxd`, both FFs reset to 1. A third FF holds the previous synchronised value for edge detection.
- Bit timer: counter `cnt` 0..DIV-1 with a load value. Width is `$clog2(DIV)`.
- FSM:
  - **IDLE**: on a synchronised falling edge (prev=1, cur=0), load `cnt` with `DIV/2` and go to START.
  - **START**: when `cnt` expires, sample the line. If it is 1 (false start), go to IDLE with no output. If it is 0, set `bitidx`=0, reload `DIV`, go to DATA.
  - **DATA**: on each expiry, shift the sample into `shreg` LSB-first (shift right, new bit at [7]). After `bitidx`=7, go to STOP.
  - **STOP**: on expiry, sample the line.
    - If 1: in the next cycle, load `data`=`shreg` and `led`=`shreg`, and set `valid`=1. If `valid` was already 1 and `ack`=0 in that cycle, also set `overrun`=1.
    - If 0: pulse `frame_err` for 1 cycle; `data`, `led` and `valid` are unchanged.
    - Either way, go to IDLE.
- Handshake:
  - `ack`=1 while `valid`=1 clears both `valid` and `overrun` on the next edge.
  - `ack` while `valid`=0 is ignored.
  - If `ack` and a new-byte load land in the same cycle, the new byte wins: `valid` stays 1 and `overrun` stays 0.
- Break (line held low): produces `frame_err` once. No new start is detected until the line has gone high and then falls again.
- Reset, asserted at any time including mid-frame: immediately returns to IDLE. All outputs go to 0 (`data`, `led`, `valid`, `overrun`, `frame_err`, `busy`). Sync FFs go to 1 and `shreg` to 0.

## Timing
- Edge-to-FSM latency: 2 cycles after the `rxd` transition reaches the synchroniser output.
- Let t0 be the cycle IDLE→START is taken.
  - Start sample: t0+DIV/2.
  - Data bit i: t0+DIV/2+DIV·(i+1).
  - Stop bit: t0+DIV/2+9·DIV.
  - `valid` rises 1 cycle after the stop sample.
- The `frame_err` pulse comes in the same cycle in which `valid` would have risen.
- `busy` is 1 from t0 through the stop-sample cycle.
- The next start is detectable in the cycle after STOP→IDLE (mid stop bit). This tolerates back-to-back frames.
- Accumulated baud error must be < DIV/2 over 9.5 bits. The default gives 0.06%.

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_t` {IDLE, START, DATA, STOP};
  - constant `UART_BITS`=8;
  - function `uart_div(clk_hz, baud)`.
- Sub-module `uart_bit_timer`: a loadable down-counter with an `expire` pulse. `uart_rx_monitor` instantiates it once. The FSM, shift register and handshake live in the top.

## Test plan
Use `CLK_HZ`=160, `BAUD`=10 (`DIV`=16) for speed.
- **Single byte**: send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop). Required: `valid` rises 1 cycle after the stop sample, `data`=`led`=0xA5, `busy` low afterwards, `frame_err`=0.
- **False start**: a 4-cycle low glitch on `rxd`. Required: `busy` rises and then falls at t0+8 with no `valid` and no `frame_err`.
- **Frame error**: send 0x3C with stop=0. Required: one `frame_err` pulse, `valid`=0, `led` unchanged from its previous value (0xA5).
- **Overrun and ack**: send 0x11 then 0x22 back-to-back with `ack` held at 0. Required: `data`=0x22, `overrun`=1. Then pulse `ack`: next cycle `valid`=0, `overrun`=0.
- **Simultaneous ack and load**: hold `valid`=1 with 0x11, then assert `ack` in the exact cycle 0x22 loads. Required: `valid`=1, `data`=0x22, `overrun`=0.
- **Reset mid-frame**: assert `reset_n`=0 during data bit 3 of 0xFF. Required: all outputs 0 asynchronously. After release, a full 0x5A frame is received correctly.
